// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter (and later the receiver).
// PARITY is always enumerated; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_states_e;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Integer bit-time divider: counts 0..DIV-1, strobes tick on the terminal count.
// clear holds the count at zero so a new bit always starts a full period.
module uart_baud_gen #(
  parameter int DIV   = 868,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, start + LSB-first data + stop.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W    = $clog2(DATA_WIDTH + 1);

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_states_e            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      baud_count;
  logic                  baud_tick;
  logic                  baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // Every state change outside IDLE lands on a terminal count, which already
  // clears the divider; IDLE holds it at zero so START gets a full bit time.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .DIV   (BAUD_DIV),
    .CNT_W (CNT_W)
  ) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .count (baud_count),
    .tick  (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE) begin
      assert (baud_count == '0);
    end
  end

  // tx_o, ready_o and busy_o are assigned from the next state so they
  // change on the same edge as the state and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      tx_o       <= 1'b1;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (valid_i && ready_o) begin
            state      <= START;
            shift_reg  <= data_i;
            tx_o       <= 1'b0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= PARITY_ODD ? ~^data_i : ^data_i;
`endif
          end else begin
            tx_o    <= 1'b1;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end

        START: begin
          if (baud_tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_o    <= shift_reg[0];
          end
        end

        DATA: begin
          if (baud_tick) begin
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_o    <= parity_bit;
`else
              state   <= STOP;
              tx_o    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= shift_reg[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx_o    <= 1'b1;
          end
        end
`endif

        // The bit counter is reused here to count stop bits.
        STOP: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= IDLE;
              bit_cnt <= '0;
              ready_o <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          tx_o    <= 1'b1;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a serial monitor decodes frames off tx_o
// and compares them against words queued at each accepted handshake.
module tb_uart_tx;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int DW        = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ODD   = 1'b0;
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_CYC = (1 + DW + PAR_BITS + STOP_BITS) * BAUD_DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          tx_o;
  logic          busy_o;

  int            check_count = 0;
  int            error_count = 0;
  int            cycle = 0;
  int            frames_seen = 0;
  int            start_times[$];
  logic [DW-1:0] exp_q[$];
  logic          last_parity = 1'b0;
  logic          aborted = 1'b0;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_WIDTH (DW),
    .STOP_BITS  (STOP_BITS)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD (PAR_ODD)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, observed, expected, cycle);
    end
  endtask

  // Drives one word and waits (bounded) for the handshake; hold keeps valid_i high.
  task automatic applyStimulus(input logic [DW-1:0] word, input bit hold);
    int waited = 0;
    data_i  = word;
    valid_i = 1'b1;
    while (!ready_o && waited < 4 * FRAME_CYC) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      checkOutput("accept_timeout", 32'(ready_o), 32'd1);
      valid_i = 1'b0;
    end else begin
      exp_q.push_back(word);
      @(posedge clk);
      #1;
      if (!hold) valid_i = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitBits(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) aborted = 1'b1;
    end
  endtask

  // Serial monitor: samples each bit at its centre, discards frames cut by reset.
  initial begin : monitor
    logic [DW-1:0] got;
    logic [DW-1:0] exp_word;
    logic          start_bit;
    logic          par_bit;
    logic          stop_ok;
    par_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_o === 1'b0) begin
        start_times.push_back(cycle);
        aborted = 1'b0;
        waitBits(BAUD_DIV / 2 - 1);
        start_bit = tx_o;
        for (int i = 0; i < DW; i++) begin
          waitBits(BAUD_DIV);
          got[i] = tx_o;
        end
        if (PAR_BITS != 0) begin
          waitBits(BAUD_DIV);
          par_bit = tx_o;
        end
        stop_ok = 1'b1;
        for (int s = 0; s < STOP_BITS; s++) begin
          waitBits(BAUD_DIV);
          stop_ok = stop_ok & tx_o;
        end
        if (aborted) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          checkOutput("spurious_frame", 32'd1, 32'd0);
        end else begin
          exp_word = exp_q.pop_front();
          frames_seen++;
          checkOutput("start_bit", 32'(start_bit), 32'd0);
          checkOutput("data", 32'(got), 32'(exp_word));
          checkOutput("stop_bit", 32'(stop_ok), 32'd1);
`ifdef UART_TX_PARITY_EN
          last_parity = par_bit;
          checkOutput("parity", 32'(par_bit), 32'(PAR_ODD ? ~^exp_word : ^exp_word));
`endif
        end
      end
    end
  end

  initial begin : main
    int cnt;
    int n0;
    int f0;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(tx_o), 32'd1);
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;

    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (!tx_o || busy_o) cnt++;
    end
    checkOutput("idle_quiet", 32'(cnt), 32'd0);
    checkOutput("idle_ready", 32'(ready_o), 32'd1);

    $display("[TB] single word 0xA5");
    applyStimulus(8'hA5, 1'b0);
    checkOutput("busy_in_frame", 32'(busy_o), 32'd1);
    cnt = 0;
    while (!ready_o && cnt < 4 * FRAME_CYC) begin
      @(negedge clk);
      if (!ready_o) cnt++;
    end
    checkOutput("ready_low_cycles", 32'(cnt), 32'(FRAME_CYC));
    waitDrain();

    $display("[TB] back-to-back 0x00 then 0xFF");
    n0 = start_times.size();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    waitDrain();
    checkOutput("b2b_frames", 32'(start_times.size() - n0), 32'd2);
    if (start_times.size() >= n0 + 2)
      checkOutput("b2b_gap", 32'(start_times[n0+1] - start_times[n0]), 32'(FRAME_CYC + 1));

    $display("[TB] valid pulse while busy is ignored");
    f0 = frames_seen;
    applyStimulus(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("busy_not_ready", 32'(ready_o), 32'd0);
    data_i  = 8'h3C;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = '0;
    waitDrain();
    repeat (2 * FRAME_CYC) @(negedge clk);
    checkOutput("ignore_frames", 32'(frames_seen - f0), 32'd1);
    checkOutput("ignore_idle", 32'(busy_o), 32'd0);

    $display("[TB] reset during data bit 3");
    applyStimulus(8'hC3, 1'b0);
    repeat (4 * BAUD_DIV + BAUD_DIV / 2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tx", 32'(tx_o), 32'd1);
    checkOutput("midrst_ready", 32'(ready_o), 32'd1);
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CYC + 20) @(negedge clk);
    waitDrain();
    f0 = frames_seen;
    applyStimulus(8'h81, 1'b0);
    waitDrain();
    checkOutput("after_rst_frames", 32'(frames_seen - f0), 32'd1);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity of 0x07");
    applyStimulus(8'h07, 1'b0);
    waitDrain();
    checkOutput("parity_07", 32'(last_parity), 32'd1);
`endif

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
